iob_vexriscv_bus_arb: RTL
=========================

# iob_vexriscv_bus_arb

Two-master to one-slave arbiter for the IOb native bus that lets the VexRiscv instruction and data buses share a single memory port (e.g. one external-memory or single-port SRAM interface). Arbitration is round-robin and a stalled request keeps its grant until it is accepted. Read responses are returned in order and routed back to the issuing master through an ID FIFO, so several reads can be outstanding.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- PEND_W, 2, log2 of the maximum number of outstanding reads (depth 2**PEND_W)
- clk_i  input  1  system clock
- cke_i  input  1  clock enable; when low, all registers hold
- arst_n_i  input  1  asynchronous active-low reset
- i_avalid_i, i_addr_i[ADDR_W], i_wdata_i[DATA_W], i_wstrb_i[DATA_W/8]  input  instruction-master request
- i_ready_o  output  1  instruction request accepted this cycle
- i_rvalid_o  output  1  read data valid for the instruction master
- i_rdata_o  output  DATA_W  read data, driven directly from s_rdata_i
- d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i  input  data-master request, same widths as the instruction master
- d_ready_o, d_rvalid_o, d_rdata_o  output  data-master response, same as the instruction master
- s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o  output  request to the slave, taken from the granted master
- s_ready_i  input  1  slave accepts the request
- s_rvalid_i  input  1  slave read data valid (returned in order)
- s_rdata_i  input  DATA_W  slave read data
- pending_o  output  PEND_W+1  number of outstanding reads
- err_o  output  1  sticky flag: s_rvalid_i arrived with no read outstanding

## Operation
- **Transfer types.** A request with wstrb==0 is a read and expects exactly one s_rvalid_i. A request with wstrb!=0 is a write and completes on acceptance.
- **Acceptance.** accept = s_avalid_o & s_ready_i.
- **Full condition.** full = (pending == 2**PEND_W). While full, s_avalid_o = 0 and both ready outputs = 0.
- **Grant selection** (combinational from the request inputs, last_grant and the lock registers):
  - If locked, grant = lock_id.
  - Otherwise, if exactly one master is valid, grant that master.
  - If both are valid, grant the master that is not last_grant.
- **Slave request.** s_* = the granted master's request fields; s_avalid_o = granted avalid & ~full.
- **Ready outputs.** g_ready_o = s_ready_i & ~full for the granted master. The non-granted master's ready = 0.
- **Lock register.** Set to the granted master when s_avalid_o=1 and s_ready_i=0. Cleared on accept.
- **last_grant register.** Updated to the granted master on accept. Reset value = instruction master, so the data master wins the first tie.
- **ID FIFO** (depth 2**PEND_W, 1-bit entries: 0 = I, 1 = D):
  - Push the granted master's ID on an accepted read.
  - Pop on s_rvalid_i when not empty.
  - Push and pop in the same cycle leave pending unchanged; the pointers wrap modulo the depth.
- **Response routing.** i_rvalid_o = s_rvalid_i & ~empty & head==0; d_rvalid_o = s_rvalid_i & ~empty & head==1.
- **Spurious response.** s_rvalid_i while empty: no pop, err_o set to 1 and held until reset.
- **Throughput.** When full and a pop arrives, no acceptance happens in that cycle; requests resume the next cycle.

## Timing
- **Request path.** Zero latency: a master request appears on s_* in the same cycle, and ready is combinational from s_ready_i.
- **Response path.** Zero latency from s_rvalid_i to the master rvalid.
- **Throughput.** One accepted transfer per cycle.
- **Reset values.** pending_o=0, err_o=0, lock cleared, last_grant=I, FIFO empty.
- **Outputs in reset.** With no requests, s_avalid_o=0, i/d_ready_o=0 and i/d_rvalid_o=0.
- **Reset during operation.** Reset asserted mid-transaction discards outstanding IDs; any later s_rvalid_i then sets err_o.
- **Grant stability.** The grant never changes while s_avalid_o=1 and s_ready_i=0.
- **Clock enable.** With cke_i=0, state holds, but the combinational outputs still follow the inputs.

## Test plan
- **Single read.** I reads 0x100, s_ready_i=1, s_rvalid_i=1 with 0x12345678 one cycle later -> i_rvalid_o=1, i_rdata_o=0x12345678, d_rvalid_o=0, pending_o 0→1→0.
- **Round-robin.** Both masters issue reads continuously after reset, slave always ready -> grant order D, I, D, I. Responses returned in order are routed to D, I, D, I.
- **Lock.** I requests with s_ready_i=0 for 3 cycles; D raises avalid in cycle 1 -> s_addr_o stays I's address, d_ready_o=0, until I is accepted in cycle 3. D is accepted in cycle 4.
- **FIFO full.** PEND_W=2: four D reads accepted with no response -> pending_o=4. Fifth request: s_avalid_o=0 and d_ready_o=0. One s_rvalid_i -> pending_o=3, and the fifth request is accepted in the next cycle.
- **Write.** D writes wstrb=0xF, data 0xCAFEBABE -> accepted in the same cycle, pending_o stays 0, no rvalid expected.
- **Spurious response and reset.** s_rvalid_i while empty -> err_o=1 and held. Asserting arst_n_i=0 clears err_o, pending_o and last_grant.

Source files
------------

// File: rtl/iob_vexriscv_bus_arb.sv
// -----------------------------------------------------------------------------
// iob_vexriscv_bus_arb
//
// Shares one IOb native slave port between the VexRiscv instruction (I) and
// data (D) masters. Arbitration is round-robin. A request that the slave
// stalls keeps its grant until it is accepted. Read responses come back in
// order and are steered to the issuing master by a small ID FIFO, which lets
// up to 2**PEND_W reads be outstanding.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width (strobe width is DATA_W/8)
//   PEND_W  log2 of the maximum number of outstanding reads
//
// Ports
//   clk_i, cke_i, arst_n_i          clock, clock enable, async active-low reset
//   i_* / d_*                       instruction / data master request + response
//   s_*                             request to, and response from, the slave
//   pending_o                       number of outstanding reads
//   err_o                           sticky: read data arrived with nothing pending
// -----------------------------------------------------------------------------
module iob_vexriscv_bus_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,

    input  logic                i_avalid_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    input  logic [DATA_W-1:0]   i_wdata_i,
    input  logic [DATA_W/8-1:0] i_wstrb_i,
    output logic                i_ready_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,

    input  logic                d_avalid_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_ready_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,

    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,

    output logic [PEND_W:0]     pending_o,
    output logic                err_o
);

    localparam int DEPTH = 2 ** PEND_W;

    // Master identifiers used for grant, lock and FIFO entries.
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    localparam logic [PEND_W:0] FULL_CNT = {1'b1, {PEND_W{1'b0}}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              lock_valid_reg, lock_valid_next;
    logic              lock_id_reg,    lock_id_next;
    logic              last_grant_reg, last_grant_next;
    logic              err_reg,        err_next;
    logic [PEND_W:0]   count_reg,      count_next;
    logic [PEND_W-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [PEND_W-1:0] rd_ptr_reg,     rd_ptr_next;
    // ID storage is kept in flops rather than RAM: the head entry must be
    // readable in the same cycle as s_rvalid_i to route the response.
    logic [DEPTH-1:0]  fifo_reg;
    logic [DEPTH-1:0]  wr_sel;

    // -------------------------------------------------------------------------
    // Grant and slave request
    // -------------------------------------------------------------------------
    logic grant;
    logic g_avalid;
    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;
    logic head;

    always_comb begin
        grant = ID_I;
        if (lock_valid_reg) begin
            grant = lock_id_reg;
        end else if (i_avalid_i && d_avalid_i) begin
            grant = ~last_grant_reg;
        end else if (d_avalid_i) begin
            grant = ID_D;
        end
    end

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

    assign g_avalid  = (grant == ID_D) ? d_avalid_i : i_avalid_i;
    assign s_addr_o  = (grant == ID_D) ? d_addr_i   : i_addr_i;
    assign s_wdata_o = (grant == ID_D) ? d_wdata_i  : i_wdata_i;
    assign s_wstrb_o = (grant == ID_D) ? d_wstrb_i  : i_wstrb_i;

    // A full ID FIFO blocks every request, writes included, so that ordering
    // against outstanding reads is preserved on the slave side.
    assign s_avalid_o = g_avalid & ~full;
    assign accept     = s_avalid_o & s_ready_i;

    // Ready is only raised towards a master that is actually requesting; the
    // handshake is identical and idle masters see a quiet ready.
    assign i_ready_o = accept & (grant == ID_I);
    assign d_ready_o = accept & (grant == ID_D);

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    assign push = accept & (s_wstrb_o == '0);
    assign pop  = s_rvalid_i & ~empty;
    assign head = fifo_reg[rd_ptr_reg];

    assign i_rvalid_o = pop & (head == ID_I);
    assign d_rvalid_o = pop & (head == ID_D);
    assign i_rdata_o  = s_rdata_i;
    assign d_rdata_o  = s_rdata_i;

    assign pending_o = count_reg;
    assign err_o     = err_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        lock_valid_next = lock_valid_reg;
        lock_id_next    = lock_id_reg;
        last_grant_next = last_grant_reg;
        err_next        = err_reg;
        count_next      = count_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;

        // Hold the grant across a slave stall so the request cannot be
        // swapped out from under the slave.
        if (accept) begin
            lock_valid_next = 1'b0;
            last_grant_next = grant;
        end else if (s_avalid_o && !s_ready_i) begin
            lock_valid_next = 1'b1;
            lock_id_next    = grant;
        end

        if (s_rvalid_i && empty) begin
            err_next = 1'b1;
        end

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PEND_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PEND_W'(1);
        end

        if (push && !pop) begin
            count_next = count_reg + (PEND_W+1)'(1);
        end else if (pop && !push) begin
            count_next = count_reg - (PEND_W+1)'(1);
        end
    end

    // One-hot write select for the ID storage.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push & (wr_ptr_reg == PEND_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock_valid_reg <= 1'b0;
            lock_id_reg    <= ID_I;
            last_grant_reg <= ID_I;
            err_reg        <= 1'b0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_reg       <= '0;
        end else if (cke_i) begin
            lock_valid_reg <= lock_valid_next;
            lock_id_reg    <= lock_id_next;
            last_grant_reg <= last_grant_next;
            err_reg        <= err_next;
            count_reg      <= count_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_sel[k]) begin
                    fifo_reg[k] <= grant;
                end
            end
        end
    end

endmodule
